ga_sync_irq: RTL and testbench

//  Gate-Array side receiver of the CRTC sync outputs for the CPC core. Samples

---
 rtl/ga_sync_irq.sv | 142 ++++++++++++++
 tb/tb_ga_sync_irq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ga_sync_irq.sv
// Gate-Array sync receiver: regenerates monitor HSYNC/VSYNC/CSYNC from the CRTC syncs,
// runs the 52-line raster interrupt counter with VSYNC resync, and latches the video mode.
module ga_sync_irq #(
  parameter int HS_DELAY  = 2,
  parameter int HS_WIDTH  = 4,
  parameter int VS_LINES  = 26,
  parameter int IRQ_LINES = 52
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic [1:0] MODE_IN,
  input  logic       IRQ_CLR,
  input  logic       IRQ_ACK,
  output logic       INT,
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic       CSYNC,
  output logic [1:0] MODE_O,
  output logic [5:0] LINE_CNT
);

  localparam logic [4:0] HS_LO   = 5'(HS_DELAY);
  localparam logic [4:0] HS_HI   = 5'(HS_DELAY + HS_WIDTH);
  localparam logic [4:0] VL_LAST = 5'(VS_LINES - 1);
  localparam logic [5:0] IRQ_CNT = 6'(IRQ_LINES);

  logic       hs_s_q, hs_s_d;
  logic       vs_s_q, vs_s_d;
  logic [3:0] hs_age_q, hs_age_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [4:0] vl_cnt_q, vl_cnt_d;
  logic [1:0] vdly_q, vdly_d;
  logic [5:0] line_q, line_d;
  logic       int_q, int_d;
  logic [1:0] mode_q, mode_d;

  logic       hs_fall, vs_rise, resync, line_event;
  logic [5:0] line_inc;

  assign hs_fall    = hs_s_q & ~HSYNC_IN;
  assign vs_rise    = ~vs_s_q & VSYNC_IN;
  assign line_event = CLKEN & hs_fall;
  assign resync     = line_event & (vdly_q == 2'd1);
  assign line_inc   = line_q + 6'd1;

  always_comb begin
    hs_s_d   = hs_s_q;
    vs_s_d   = vs_s_q;
    hs_age_d = hs_age_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    vl_cnt_d = vl_cnt_q;
    vdly_d   = vdly_q;
    mode_d   = mode_q;
    if (CLKEN) begin
      hs_s_d = HSYNC_IN;
      vs_s_d = VSYNC_IN;
      if (!HSYNC_IN)               hs_age_d = 4'd0;
      else if (hs_age_q != 4'hF)   hs_age_d = hs_age_q + 4'd1;
      else                         hs_age_d = 4'hF;
      hsync_d = HSYNC_IN & ({1'b0, hs_age_d} > HS_LO) & ({1'b0, hs_age_d} <= HS_HI);
      if (hsync_d && !hsync_q) mode_d = MODE_IN;
      // VSYNC_O length counts CRTC line ends only; the CRTC VSYNC fall is ignored.
      if (vs_rise) begin
        vsync_d  = 1'b1;
        vl_cnt_d = 5'd0;
      end else if (hs_fall && vsync_q) begin
        if (vl_cnt_q == VL_LAST) begin
          vsync_d  = 1'b0;
          vl_cnt_d = 5'd0;
        end else begin
          vl_cnt_d = vl_cnt_q + 5'd1;
        end
      end
      if (vs_rise)                      vdly_d = 2'd2;
      else if (hs_fall && vdly_q != 0)  vdly_d = vdly_q - 2'd1;
    end
  end

  // Acknowledge is weakest, the counter event overrides it, and the CPU clear wins.
  always_comb begin
    line_d = line_q;
    int_d  = int_q;
    if (IRQ_ACK) begin
      int_d     = 1'b0;
      line_d[5] = 1'b0;
    end
    if (line_event) begin
      if (resync) begin
        line_d = 6'd0;
        if (line_q[5]) int_d = 1'b1;
      end else if (line_inc == IRQ_CNT) begin
        line_d = 6'd0;
        int_d  = 1'b1;
      end else begin
        line_d = line_inc;
      end
    end
    if (IRQ_CLR) begin
      line_d = 6'd0;
      int_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      hs_s_q   <= 1'b0;
      vs_s_q   <= 1'b0;
      hs_age_q <= 4'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vl_cnt_q <= 5'd0;
      vdly_q   <= 2'd0;
      line_q   <= 6'd0;
      int_q    <= 1'b0;
      mode_q   <= 2'd0;
    end else begin
      hs_s_q   <= hs_s_d;
      vs_s_q   <= vs_s_d;
      hs_age_q <= hs_age_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vl_cnt_q <= vl_cnt_d;
      vdly_q   <= vdly_d;
      line_q   <= line_d;
      int_q    <= int_d;
      mode_q   <= mode_d;
    end
  end

  assign INT      = int_q;
  assign HSYNC_O  = hsync_q;
  assign VSYNC_O  = vsync_q;
  assign CSYNC    = hsync_q | vsync_q;
  assign MODE_O   = mode_q;
  assign LINE_CNT = line_q;

endmodule

// File: tb/tb_ga_sync_irq.sv
// Scoreboard bench for ga_sync_irq: stimulus queues hand-computed expectations,
// a monitor process pops and compares them after each stimulus step.
module tb_ga_sync_irq;

  logic       clk;
  logic       nRESET;
  logic       CLKEN;
  logic       HSYNC_IN;
  logic       VSYNC_IN;
  logic [1:0] MODE_IN;
  logic       IRQ_CLR;
  logic       IRQ_ACK;
  logic       INT;
  logic       HSYNC_O;
  logic       VSYNC_O;
  logic       CSYNC;
  logic [1:0] MODE_O;
  logic [5:0] LINE_CNT;

  ga_sync_irq dut (
    .CLOCK   (clk),
    .nRESET  (nRESET),
    .CLKEN   (CLKEN),
    .HSYNC_IN(HSYNC_IN),
    .VSYNC_IN(VSYNC_IN),
    .MODE_IN (MODE_IN),
    .IRQ_CLR (IRQ_CLR),
    .IRQ_ACK (IRQ_ACK),
    .INT     (INT),
    .HSYNC_O (HSYNC_O),
    .VSYNC_O (VSYNC_O),
    .CSYNC   (CSYNC),
    .MODE_O  (MODE_O),
    .LINE_CNT(LINE_CNT)
  );

  localparam int S_INT = 0, S_LINE = 1, S_HS = 2, S_VS = 3, S_CS = 4, S_MODE = 5;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int actual(input int sel);
    case (sel)
      S_INT:   return int'(INT);
      S_LINE:  return int'(LINE_CNT);
      S_HS:    return int'(HSYNC_O);
      S_VS:    return int'(VSYNC_O);
      S_CS:    return int'(CSYNC);
      default: return int'(MODE_O);
    endcase
  endfunction

  // Monitor: compares every queued expectation shortly after the falling edge.
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.sel);
        n_checks++;
        if (a != e.val) begin
          n_errors++;
          $display("FAIL %s: got %0d, expected %0d", e.name, a, e.val);
        end else begin
          $display("check %s: %0d ok", e.name, a);
        end
      end
    end
  end

  task automatic want(input string name, input int sel, input int val);
    sb.push_back('{name, sel, val});
  endtask

  task automatic want_irq(input string tag, input int i, input int l);
    want({tag, "_int"}, S_INT, i);
    want({tag, "_line"}, S_LINE, l);
  endtask

  task automatic chr(input logic hs, input logic vs, input logic ack, input logic clr);
    @(negedge clk);
    HSYNC_IN = hs; VSYNC_IN = vs; IRQ_ACK = ack; IRQ_CLR = clr; CLKEN = 1'b1;
    @(negedge clk);
    CLKEN = 1'b0; IRQ_ACK = 1'b0; IRQ_CLR = 1'b0;
  endtask

  task automatic lines(input int n, input logic vs);
    for (int i = 0; i < n; i++) begin
      chr(1'b1, vs, 1'b0, 1'b0);
      chr(1'b0, vs, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse(input logic ack, input logic clr);
    @(negedge clk);
    IRQ_ACK = ack; IRQ_CLR = clr;
    @(negedge clk);
    IRQ_ACK = 1'b0; IRQ_CLR = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    nRESET = 1'b0; CLKEN = 1'b0; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
    IRQ_ACK = 1'b0; IRQ_CLR = 1'b0;
    want({tag, "_int"},  S_INT,  0);
    want({tag, "_line"}, S_LINE, 0);
    want({tag, "_hs"},   S_HS,   0);
    want({tag, "_vs"},   S_VS,   0);
    want({tag, "_cs"},   S_CS,   0);
    want({tag, "_mode"}, S_MODE, 0);
    @(negedge clk);
    @(negedge clk);
    nRESET = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_exp;
    nRESET = 1'b0; CLKEN = 1'b0; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
    MODE_IN = 2'd0; IRQ_ACK = 1'b0; IRQ_CLR = 1'b0;

    // HSYNC_O window: high after chars 3..6 of a 14-char CRTC HSYNC.
    do_reset("rst0");
    for (int k = 1; k <= 14; k++) begin
      chr(1'b1, 1'b0, 1'b0, 1'b0);
      hs_exp = (k >= 3 && k <= 6) ? 1 : 0;
      want($sformatf("hs14_k%0d", k), S_HS, hs_exp);
      want($sformatf("cs14_k%0d", k), S_CS, hs_exp);
    end
    chr(1'b0, 1'b0, 1'b0, 1'b0);
    want("hs14_end", S_HS, 0);
    want("hs14_line", S_LINE, 1);

    do_reset("rst1");
    chr(1'b1, 1'b0, 1'b0, 1'b0); want("hs2_k1", S_HS, 0);
    chr(1'b1, 1'b0, 1'b0, 1'b0); want("hs2_k2", S_HS, 0);
    chr(1'b0, 1'b0, 1'b0, 1'b0); want("hs2_end", S_HS, 0);

    // 52-line interrupt period.
    do_reset("rst2");
    lines(51, 1'b0); want_irq("p51", 0, 51);
    lines(1, 1'b0);  want_irq("p52", 1, 0);
    lines(1, 1'b0);  want_irq("p53", 1, 1);
    lines(7, 1'b0);  want_irq("p60", 1, 8);
    pulse(1'b1, 1'b0); want_irq("p60ack", 0, 8);
    lines(43, 1'b0); want_irq("p103", 0, 51);
    lines(1, 1'b0);  want_irq("p104", 1, 0);

    // Acknowledge, clear and their coincidence with counter events.
    do_reset("rst3");
    lines(92, 1'b0); want_irq("a92", 1, 40);
    pulse(1'b1, 1'b0); want_irq("ack40", 0, 8);
    lines(43, 1'b0); want_irq("a51", 0, 51);
    chr(1'b1, 1'b0, 1'b0, 1'b0);
    chr(1'b0, 1'b0, 1'b1, 1'b0); want_irq("ackwrap", 1, 0);
    lines(5, 1'b0);  want_irq("a5", 1, 5);
    chr(1'b1, 1'b0, 1'b0, 1'b0);
    chr(1'b0, 1'b0, 1'b0, 1'b1); want_irq("clrfall", 0, 0);
    lines(3, 1'b0);  want_irq("a3", 0, 3);
    pulse(1'b0, 1'b1); want_irq("clr3", 0, 0);

    // VSYNC resync below and above 32.
    do_reset("rst4");
    lines(30, 1'b0); want_irq("r30", 0, 30);
    chr(1'b0, 1'b1, 1'b0, 1'b0);
    lines(1, 1'b1);  want_irq("r30f1", 0, 31);
    lines(1, 1'b1);  want_irq("r30f2", 0, 0);
    lines(1, 1'b1);  want_irq("r30f3", 0, 1);
    do_reset("rst5");
    lines(35, 1'b0);
    chr(1'b0, 1'b1, 1'b0, 1'b0);
    lines(1, 1'b1);  want_irq("r35f1", 0, 36);
    lines(1, 1'b1);  want_irq("r35f2", 1, 0);

    // VSYNC_O lasts 26 line ends regardless of a 16-line CRTC VSYNC.
    do_reset("rst6");
    chr(1'b0, 1'b1, 1'b0, 1'b0);
    want("vs_rise", S_VS, 1);
    want("cs_rise", S_CS, 1);
    for (int k = 1; k <= 27; k++) begin
      lines(1, (k <= 15) ? 1'b1 : 1'b0);
      want($sformatf("vs_l%0d", k), S_VS, (k < 26) ? 1 : 0);
      want($sformatf("cs_l%0d", k), S_CS, (k < 26) ? 1 : 0);
    end

    // Mode latched only at HSYNC_O rise; asynchronous reset mid-pulse.
    do_reset("rst7");
    chr(1'b0, 1'b0, 1'b0, 1'b0);
    MODE_IN = 2'd2;
    chr(1'b0, 1'b0, 1'b0, 1'b0); want("mode_mid", S_MODE, 0);
    chr(1'b1, 1'b0, 1'b0, 1'b0); want("mode_k1", S_MODE, 0);
    chr(1'b1, 1'b0, 1'b0, 1'b0); want("mode_k2", S_MODE, 0);
    chr(1'b1, 1'b0, 1'b0, 1'b0); want("mode_k3", S_MODE, 2);
    MODE_IN = 2'd1;
    chr(1'b1, 1'b0, 1'b0, 1'b0); want("mode_hold", S_MODE, 2);
    chr(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) chr(1'b1, 1'b0, 1'b0, 1'b0);
    want("mode_next", S_MODE, 1);
    chr(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) chr(1'b1, 1'b1, 1'b0, 1'b0);
    want("pre_hs", S_HS, 1);
    want("pre_vs", S_VS, 1);
    do_reset("rst8");

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
